// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction-fetch unit with credit-limited memory requests and prefetch FIFO
module ifu_prefetch #(
    parameter int                   CPU_WIDTH       = 32,
    parameter int                   FIFO_DEPTH      = 4,
    parameter int                   MAX_OUTSTANDING = 2,
    parameter logic [CPU_WIDTH-1:0] RESET_PC        = '0,
    parameter int                   PC_STEP         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect_valid,
    input  logic [CPU_WIDTH-1:0]          redirect_pc,
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [CPU_WIDTH-1:0]          imem_req_addr,
    input  logic                          imem_rsp_valid,
    input  logic [CPU_WIDTH-1:0]          imem_rsp_data,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [CPU_WIDTH-1:0]          inst,
    output logic [CPU_WIDTH-1:0]          inst_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = ((OW > CW) ? OW : CW) + 1;

    localparam logic [CPU_WIDTH-1:0] STEP    = CPU_WIDTH'(PC_STEP);
    localparam logic [OW-1:0]        MAX_OUT = OW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0]        DEPTH_S = SW'(FIFO_DEPTH);

    // Architectural state
    logic [CPU_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CPU_WIDTH-1:0]   rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]          outstanding_q, outstanding_d;
    logic [OW-1:0]          discard_q, discard_d;
    logic [CW-1:0]          count_q, count_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [2*CPU_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [SW-1:0]          credit_sum;
    logic                   accept;
    logic                   rsp_take;
    logic                   rsp_drop;
    logic                   push;
    logic                   pop;
    logic [2*CPU_WIDTH-1:0] head;

    // Handshake decode: a request is only offered when a FIFO slot is reserved for its response
    always_comb begin
        credit_sum     = SW'(outstanding_q) + SW'(count_q);
        imem_req_valid = !rst && !redirect_valid
                         && (outstanding_q < MAX_OUT)
                         && (credit_sum < DEPTH_S);
        accept         = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a memory protocol error; ignore it
        rsp_take       = imem_rsp_valid && (outstanding_q != '0);
        rsp_drop       = (discard_q != '0);
        push           = rsp_take && !rsp_drop && !redirect_valid;
        inst_valid     = (count_q != '0) && !redirect_valid;
        pop            = inst_valid && inst_ready;
    end

    // Next-state computation; a redirect overrides the normal PC/FIFO updates
    always_comb begin
        outstanding_d = outstanding_q + OW'(accept) - OW'(rsp_take);
        discard_d     = discard_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        count_d       = count_q + CW'(push) - CW'(pop);
        wr_ptr_d      = wr_ptr_q + AW'(push);
        rd_ptr_d      = rd_ptr_q + AW'(pop);

        if (rsp_take && rsp_drop) begin
            discard_d = discard_q - 1'b1;
        end
        if (accept) begin
            fetch_pc_d = fetch_pc_q + STEP;
        end
        if (push) begin
            rsp_pc_d = rsp_pc_q + STEP;
        end

        if (redirect_valid) begin
            // Everything still in flight belongs to the old path
            discard_d  = outstanding_d;
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Prefetch storage: each entry is {instruction, pc}; contents are qualified by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {imem_rsp_data, rsp_pc_q};
        end
    end

    // Head presentation, forced to zero whenever nothing is offered
    always_comb begin
        head          = mem_q[rd_ptr_q];
        inst          = inst_valid ? head[2*CPU_WIDTH-1:CPU_WIDTH] : '0;
        inst_pc       = inst_valid ? head[CPU_WIDTH-1:0] : '0;
        imem_req_addr = fetch_pc_q;
        fifo_count    = count_q;
    end

    // Stale-response bookkeeping can never exceed what is actually in flight
    a_discard_le_outstanding: assert property (@(posedge clk) disable iff (rst)
        discard_q <= outstanding_q);

endmodule
